// File: rtl/hex_dump_fmt.sv
// hex_dump_fmt
// Turns a stream of (address, byte) pairs into an ASCII hex dump. Characters
// go to the uart one per out_wr strobe, in lines of the form
//   "AAAA: HH HH ... HH\r\n"
// with BYTES_PER_LINE bytes per line. The address field is printed only for
// the first byte of a line and is taken from that byte's in_addr.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   in_data   byte to print
//   in_addr   byte address of in_data (15 bits, printed as 4 hex digits)
//   in_valid  in_data/in_addr valid
//   in_ready  formatter can accept a byte (idle and not in reset)
//   out_data  ASCII character for the uart (holds when out_wr is low)
//   out_wr    one-cycle write strobe to the uart
//   tx_ready  uart tx_empty
//   busy      high while a byte is being formatted
module hex_dump_fmt #(
    parameter int BYTES_PER_LINE = 16,
    parameter int TX_HOLDOFF     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic [14:0] in_addr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_wr,
    input  logic        tx_ready,
    output logic        busy
);

    localparam int               COL_W     = $clog2(BYTES_PER_LINE) + 1;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(BYTES_PER_LINE - 1);
    localparam logic [3:0]       HOLD_LOAD = 4'(TX_HOLDOFF);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        COLON,
        SPC0,
        HI,
        LO,
        SEP,
        CR,
        LF
    } state_t;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [3:0]       hold_reg, hold_next;
    logic [1:0]       nib_reg, nib_next;
    logic [7:0]       data_reg, data_next;
    logic [14:0]      addr_reg, addr_next;
    logic [7:0]       out_data_reg, out_data_next;
    logic             out_wr_reg, out_wr_next;

    // Nibble to uppercase ASCII hex digit.
    logic [7:0] hex_lut [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hex
            if (gi < 10) begin : g_digit
                assign hex_lut[gi] = 8'(8'h30 + gi);
            end else begin : g_alpha
                assign hex_lut[gi] = 8'(8'h41 + gi - 10);
            end
        end
    endgenerate

    // The address is printed as 16 bits with a zero MSB; nib_reg counts
    // down from 3 so the most significant digit comes out first.
    logic [15:0] addr_word;
    logic [3:0]  addr_nib;
    logic [7:0]  cur_char;

    assign addr_word = {1'b0, addr_reg};
    assign addr_nib  = addr_word[{nib_reg, 2'b00} +: 4];

    always_comb begin
        cur_char = 8'h00;
        case (state_reg)
            ADDR:      cur_char = hex_lut[addr_nib];
            COLON:     cur_char = 8'h3A;
            SPC0, SEP: cur_char = 8'h20;
            HI:        cur_char = hex_lut[data_reg[7:4]];
            LO:        cur_char = hex_lut[data_reg[3:0]];
            CR:        cur_char = 8'h0D;
            LF:        cur_char = 8'h0A;
            default:   cur_char = 8'h00;
        endcase
    end

    assign in_ready = (state_reg == IDLE) && !rst;
    assign out_data = out_data_reg;
    assign out_wr   = out_wr_reg;
    assign busy     = (state_reg != IDLE);

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        nib_next      = nib_reg;
        data_next     = data_reg;
        addr_next     = addr_reg;
        out_data_next = out_data_reg;
        out_wr_next   = 1'b0;
        // Holdoff runs down in every state, including IDLE, so a new byte
        // still waits out the uart's tx_empty update latency.
        hold_next     = (hold_reg != 4'd0) ? hold_reg - 4'd1 : 4'd0;

        if (state_reg == IDLE) begin
            if (in_valid && in_ready) begin
                data_next  = in_data;
                addr_next  = in_addr;
                nib_next   = 2'd3;
                state_next = (col_reg == '0) ? ADDR : HI;
            end
        end else if (tx_ready && (hold_reg == 4'd0)) begin
            // Emit the current state's character and advance on the same
            // edge; tx_ready is then ignored until the holdoff expires.
            out_wr_next   = 1'b1;
            out_data_next = cur_char;
            hold_next     = HOLD_LOAD;
            case (state_reg)
                ADDR: begin
                    if (nib_reg == 2'd0) begin
                        state_next = COLON;
                    end else begin
                        nib_next = nib_reg - 2'd1;
                    end
                end
                COLON:   state_next = SPC0;
                SPC0:    state_next = HI;
                HI:      state_next = LO;
                LO:      state_next = (col_reg == LAST_COL) ? CR : SEP;
                SEP: begin
                    col_next   = col_reg + 1'b1;
                    state_next = IDLE;
                end
                CR:      state_next = LF;
                LF: begin
                    col_next   = '0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            hold_reg     <= 4'd0;
            nib_reg      <= 2'd0;
            data_reg     <= 8'h00;
            addr_reg     <= 15'h0000;
            out_data_reg <= 8'h00;
            out_wr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            hold_reg     <= hold_next;
            nib_reg      <= nib_next;
            data_reg     <= data_next;
            addr_reg     <= addr_next;
            out_data_reg <= out_data_next;
            out_wr_reg   <= out_wr_next;
        end
    end

endmodule

// File: tb/tb_hex_dump_fmt.sv
// Testbench for hex_dump_fmt. Two instances: dut_a (16 bytes per line) and
// dut_b (1 byte per line). A byte-queue model predicts the character stream
// from each accepted (address, byte) pair; a negedge process compares every
// out_wr against it, and directed tests pin the stream with literal strings.
module tb_hex_dump_fmt;

    localparam int HOLD = 2;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [7:0]  in_data_a, out_data_a;
    logic [14:0] in_addr_a;
    logic        in_valid_a, in_ready_a, out_wr_a, tx_ready_a, busy_a;

    logic [7:0]  in_data_b, out_data_b;
    logic [14:0] in_addr_b;
    logic        in_valid_b, in_ready_b, out_wr_b, tx_ready_b, busy_b;

    hex_dump_fmt #(.BYTES_PER_LINE(16), .TX_HOLDOFF(HOLD)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data_a), .in_addr(in_addr_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_wr(out_wr_a),
        .tx_ready(tx_ready_a), .busy(busy_a)
    );

    hex_dump_fmt #(.BYTES_PER_LINE(1), .TX_HOLDOFF(HOLD)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data_b), .in_addr(in_addr_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_wr(out_wr_b),
        .tx_ready(tx_ready_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bq_t exp_a, exp_b, log_a, log_b;
    int  wr_cyc_a[$];
    int  col_a = 0, col_b = 0;
    int  acc_a = 0;
    int  last_wr_cyc_a = -100;
    logic prev_tx_a = 1'b0;
    logic rst_prev = 1'b1;
    logic [7:0] last_data_a = 8'h00;

    // ---------------- model ----------------
    function automatic byte unsigned hexc(input logic [3:0] n);
        return (n < 4'd10) ? byte'(48 + int'(n)) : byte'(55 + int'(n));
    endfunction

    function automatic bq_t line_chars(input logic [14:0] a, input logic [7:0] d,
                                       input int col, input int bpl);
        bq_t q;
        logic [15:0] w;
        w = {1'b0, a};
        if (col == 0) begin
            for (int i = 3; i >= 0; i--) q.push_back(hexc(w[i*4 +: 4]));
            q.push_back(8'h3A);
            q.push_back(8'h20);
        end
        q.push_back(hexc(d[7:4]));
        q.push_back(hexc(d[3:0]));
        if (col == bpl - 1) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end else begin
            q.push_back(8'h20);
        end
        return q;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cyc++;
        // instance A
        if (out_wr_a) begin
            log_a.push_back(out_data_a);
            wr_cyc_a.push_back(cyc);
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_char got=%02h required=none", out_data_a);
            end else begin
                byte unsigned e;
                e = exp_a.pop_front();
                if (out_data_a !== e) begin
                    failures++;
                    $display("FAIL a_char got=%02h required=%02h", out_data_a, e);
                end
            end
            checks++;
            if (cyc - last_wr_cyc_a < HOLD + 1) begin
                failures++;
                $display("FAIL a_wr_spacing got=%0d required>=%0d", cyc - last_wr_cyc_a, HOLD + 1);
            end
            checks++;
            if (!prev_tx_a) begin
                failures++;
                $display("FAIL a_wr_without_tx_ready got=0 required=1");
            end
            last_wr_cyc_a = cyc;
        end else if (!rst_prev) begin
            checks++;
            if (out_data_a !== last_data_a) begin
                failures++;
                $display("FAIL a_out_data_hold got=%02h required=%02h", out_data_a, last_data_a);
            end
        end
        last_data_a = out_data_a;
        prev_tx_a   = tx_ready_a;

        // instance B
        if (out_wr_b) begin
            log_b.push_back(out_data_b);
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_char got=%02h required=none", out_data_b);
            end else begin
                byte unsigned e;
                e = exp_b.pop_front();
                if (out_data_b !== e) begin
                    failures++;
                    $display("FAIL b_char got=%02h required=%02h", out_data_b, e);
                end
            end
        end

        // model update for the edge that follows
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
            col_a = 0;
            col_b = 0;
            last_wr_cyc_a = -100;
        end else begin
            if (in_valid_a && in_ready_a) begin
                exp_a = {exp_a, line_chars(in_addr_a, in_data_a, col_a, 16)};
                col_a = (col_a == 15) ? 0 : col_a + 1;
                acc_a++;
            end
            if (in_valid_b && in_ready_b) begin
                exp_b = {exp_b, line_chars(in_addr_b, in_data_b, col_b, 1)};
                col_b = 0;
            end
        end
        rst_prev = rst;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic check_log(input string name, input bq_t got, input string req);
        string gs = "";
        string rs = "";
        bit ok;
        ok = (got.size() == req.len());
        for (int i = 0; i < got.size(); i++) begin
            gs = {gs, $sformatf("%02h ", got[i])};
            if (ok && got[i] != byte'(req[i])) ok = 0;
        end
        for (int i = 0; i < req.len(); i++) rs = {rs, $sformatf("%02h ", req[i])};
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=[%s] required=[%s]", name, gs, rs);
        end else begin
            $display("ok   %s [%s]", name, gs);
        end
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
        wr_cyc_a.delete();
    endtask

    task automatic send_a(input logic [14:0] a, input logic [7:0] d);
        int n = 0;
        in_addr_a  = a;
        in_data_a  = d;
        in_valid_a = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready_a) begin
            failures++;
            $display("FAIL send_a_timeout got=in_ready0 required=in_ready1");
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [14:0] a, input logic [7:0] d);
        int n = 0;
        in_addr_b  = a;
        in_data_b  = d;
        in_valid_b = 1'b1;
        @(negedge clk);
        while (!in_ready_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready_b) begin
            failures++;
            $display("FAIL send_b_timeout got=in_ready0 required=in_ready1");
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain(input int which);
        int n = 0;
        @(negedge clk);
        while (n < 3000 && ((which == 0) ? (exp_a.size() != 0 || busy_a)
                                         : (exp_b.size() != 0 || busy_b))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_timeout inst=%0d got=busy required=idle", which);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bq_t tail;
        int  acc0;
        int  n;
        int  cnt;

        rst = 1'b1;
        in_data_a = 8'h00; in_addr_a = 15'h0; in_valid_a = 1'b0; tx_ready_a = 1'b1;
        in_data_b = 8'h00; in_addr_b = 15'h0; in_valid_b = 1'b0; tx_ready_b = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_wr", out_wr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_out_data", out_data_a, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready_a, 1);

        // Test 1: single byte
        @(posedge clk); #1;
        clear_logs();
        send_a(15'h7FA0, 8'h3C);
        drain(0);
        check_log("t1_stream", log_a, "7FA0: 3C ");
        chk("t1_count", wr_cyc_a.size(), 9);
        if (wr_cyc_a.size() == 9)
            for (int i = 1; i < 9; i++)
                chk("t1_gap", wr_cyc_a[i] - wr_cyc_a[i-1], 3);
        chk("t1_in_ready_back", in_ready_a, 1);

        // Test 2: full 16-byte line from column 0, then 17th byte
        pulse_reset(1);
        clear_logs();
        for (int i = 0; i < 16; i++) send_a(15'h7FA0 + 15'(i), 8'(i));
        drain(0);
        chk("t2_count", log_a.size(), 55);
        tail.delete();
        for (int i = (log_a.size() >= 7 ? log_a.size() - 7 : 0); i < log_a.size(); i++)
            tail.push_back(log_a[i]);
        check_log("t2_tail", tail, "0E 0F\015\012");
        clear_logs();
        send_a(15'h7FB0, 8'h10);
        drain(0);
        check_log("t2_next_line", log_a, "7FB0: 10 ");

        // Test 3: backpressure during HI of 8'hA5
        clear_logs();
        tx_ready_a = 1'b0;
        send_a(15'h7FB1, 8'hA5);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_gap_quiet", log_a.size(), 0);
        tx_ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_resume_wr", out_wr_a, 1);
        chk("t3_resume_char", out_data_a, 8'h41);
        drain(0);
        check_log("t3_stream", log_a, "A5 ");

        // Test 4: in_valid held high, data changing every cycle
        acc0 = acc_a;
        in_valid_a = 1'b1;
        in_data_a  = 8'($urandom_range(0, 255));
        in_addr_a  = 15'($urandom_range(0, 32767));
        for (int i = 0; i < 5; i++) begin
            bit got;
            got = 0;
            n = 0;
            while (!got && n < 200) begin
                @(negedge clk);
                if (in_ready_a) got = 1;
                @(posedge clk); #1;
                in_data_a = 8'($urandom_range(0, 255));
                in_addr_a = 15'($urandom_range(0, 32767));
                n++;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL t4_accept_timeout got=in_ready0 required=in_ready1");
            end
        end
        in_valid_a = 1'b0;
        drain(0);
        chk("t4_accepted", acc_a - acc0, 5);

        // Test 5: reset mid-line
        pulse_reset(1);
        clear_logs();
        send_a(15'h7FA0, 8'h12);
        n = 0;
        while (log_a.size() < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_log("t5_partial", log_a, "7FA0: 1");
        pulse_reset(1);
        clear_logs();
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_wr_a) cnt++;
        end
        chk("t5_quiet_after_rst", cnt, 0);
        chk("t5_busy_after_rst", busy_a, 0);
        @(posedge clk); #1;
        send_a(15'h0010, 8'hFF);
        drain(0);
        check_log("t5_fresh_line", log_a, "0010: FF ");

        // Test 6: one byte per line
        clear_logs();
        send_b(15'h0000, 8'h01);
        send_b(15'h0001, 8'h02);
        drain(1);
        check_log("t6_bpl1", log_b, "0000: 01\015\0120001: 02\015\012");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
